// File: rtl/aes_block_sequencer.sv
// Word-stream front/back end for an AES core: packs 32-bit words into 129-bit blocks,
// drives key expansion and the start/done handshake, and unpacks results to words.
module aes_block_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [127:0] key_in,
    input  logic         ed_mode,
    input  logic         key_load,
    output logic         key_ready,
    output logic         timeout_err,
    output logic         key_load_err,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [128:0] core_data,
    output logic [127:0] core_key,
    output logic         core_ed_sel,
    output logic         core_key_op,
    output logic         core_start_op,
    output logic         core_r_ready,
    input  logic         core_key_expanded,
    input  logic         core_aes_done,
    input  logic [128:0] core_data_out,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_START = 3'd1,
        KEY_WAIT  = 3'd2,
        FILL      = 3'd3,
        ISSUE     = 3'd4,
        BLK_WAIT  = 3'd5,
        DRAIN     = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t       state, state_d;
    logic [1:0]   wc, rc;
    logic [7:0]   cnt;
    logic [128:0] result;
    logic         key_accept, in_fire, out_fire, in_wait, tmo_hit;

    assign state_dbg = state;

    // Both streams: a word moves on a rising edge where valid and ready are both high;
    // a producer holds its word stable from raising valid until that edge.
    always_comb begin
        in_fire    = in_valid && (state == FILL);
        out_fire   = out_ready && (state == DRAIN);
        key_accept = key_load && ((state == IDLE) || ((state == FILL) && (wc == 2'd0)));
        in_wait    = ((state == KEY_WAIT) && !core_key_expanded) ||
                     ((state == BLK_WAIT) && !core_aes_done);
        tmo_hit    = in_wait && (cnt == TMO_LAST);
        state_d    = state;
        case (state)
            IDLE:      if (key_accept) state_d = KEY_START;
            KEY_START: state_d = KEY_WAIT;
            KEY_WAIT:  if (core_key_expanded) state_d = FILL;
                       else if (tmo_hit) state_d = IDLE;
            FILL:      if (key_accept) state_d = KEY_START;
                       else if (in_fire && (wc == 2'd3)) state_d = ISSUE;
            ISSUE:     state_d = BLK_WAIT;
            BLK_WAIT:  if (core_aes_done) state_d = DRAIN;
                       else if (tmo_hit) state_d = IDLE;
            DRAIN:     if (out_fire && (rc == 2'd3)) state_d = FILL;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            core_key_op   <= 1'b0;
            core_start_op <= 1'b0;
            core_r_ready  <= 1'b0;
            timeout_err   <= 1'b0;
            key_load_err  <= 1'b0;
            key_ready     <= 1'b0;
            cnt           <= 8'd0;
            wc            <= 2'd0;
            rc            <= 2'd0;
            core_key      <= '0;
            core_ed_sel   <= 1'b0;
            core_data     <= '0;
            result        <= '0;
        end else begin
            state         <= state_d;
            in_ready      <= (state_d == FILL);
            out_valid     <= (state_d == DRAIN);
            core_key_op   <= (state_d == KEY_START);
            core_start_op <= (state_d == KEY_START) || (state_d == ISSUE);
            core_r_ready  <= (state_d == BLK_WAIT);
            timeout_err   <= tmo_hit;
            key_load_err  <= key_load && !key_accept;
            // Counter is zero on the first cycle of a wait and never runs outside one.
            cnt           <= (in_wait && !tmo_hit) ? cnt + 8'd1 : 8'd0;

            if (key_accept) begin
                core_key    <= key_in;
                core_ed_sel <= ed_mode;
                key_ready   <= 1'b0;
            end else if ((state == KEY_WAIT) && core_key_expanded) begin
                key_ready <= 1'b1;
            end else if (tmo_hit) begin
                key_ready <= 1'b0;
            end

            if (key_accept || tmo_hit) begin
                wc <= 2'd0;
            end else if (in_fire) begin
                case (wc)
                    2'd0: core_data[127:96] <= in_data;
                    2'd1: core_data[95:64]  <= in_data;
                    2'd2: core_data[63:32]  <= in_data;
                    default: begin
                        core_data[31:0] <= in_data;
                        core_data[128]  <= in_last;
                    end
                endcase
                wc <= wc + 2'd1;
            end

            if ((state == BLK_WAIT) && core_aes_done) begin
                result <= core_data_out;
                rc     <= 2'd0;
            end else if (out_fire) begin
                rc <= rc + 2'd1;
            end
        end
    end

    always_comb begin
        case (rc)
            2'd0:    out_data = result[127:96];
            2'd1:    out_data = result[95:64];
            2'd2:    out_data = result[63:32];
            default: out_data = result[31:0];
        endcase
        out_last = out_valid && (rc == 2'd3) && result[128];
    end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Randomised bench for aes_block_sequencer: a bench-side core model answers the
// start/done handshake and a word-level reference predicts every output word.
module tb_aes_block_sequencer;

    localparam int TMO = 16;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [2:0]   S_IDLE = 3'd0, S_FILL = 3'd3, S_BLK_WAIT = 3'd5;

    logic         clk, n_rst;
    logic [127:0] key_in;
    logic         ed_mode, key_load, key_ready, timeout_err, key_load_err;
    logic [31:0]  in_data, out_data;
    logic         in_last, in_valid, in_ready, out_last, out_valid, out_ready;
    logic [128:0] core_data, core_data_out;
    logic [127:0] core_key;
    logic         core_ed_sel, core_key_op, core_start_op, core_r_ready;
    logic         core_key_expanded, core_aes_done;
    logic [2:0]   state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0]  exp_q[$];
    logic [127:0] cur_key;
    logic         cur_mode;
    bit           hang = 0;
    int           blk_lat = 10;
    int           key_lat = 10;
    int           rdy_mode = 0;
    int           tmo_count = 0;

    aes_block_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .n_rst(n_rst), .key_in(key_in), .ed_mode(ed_mode), .key_load(key_load),
        .key_ready(key_ready), .timeout_err(timeout_err), .key_load_err(key_load_err),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .core_data(core_data), .core_key(core_key), .core_ed_sel(core_ed_sel),
        .core_key_op(core_key_op), .core_start_op(core_start_op), .core_r_ready(core_r_ready),
        .core_key_expanded(core_key_expanded), .core_aes_done(core_aes_done),
        .core_data_out(core_data_out), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Stand-in cipher: the known FIPS-197 vector, otherwise a mode-dependent involution.
    function automatic logic [127:0] core_ref(input logic [127:0] k, input logic m,
                                              input logic [127:0] d);
        if (k == FIPS_KEY && m && d == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && !m && d == FIPS_CT) return FIPS_PT;
        return d ^ k ^ {4{m ? 32'hc3a50f96 : 32'h1e2d3c4b}};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Core model
    initial begin : core_model
        logic [128:0] cap;
        logic [127:0] ck;
        logic         cm;
        core_key_expanded = 1'b0;
        core_aes_done     = 1'b0;
        core_data_out     = '0;
        forever begin
            @(posedge clk); #1;
            if (n_rst && core_start_op && core_key_op) begin
                repeat (key_lat) @(posedge clk);
                #1;
                core_key_expanded = 1'b1;
                @(posedge clk); #1;
                core_key_expanded = 1'b0;
            end else if (n_rst && core_start_op && !hang) begin
                cap = core_data;
                ck  = core_key;
                cm  = core_ed_sel;
                repeat (blk_lat) @(posedge clk);
                #1;
                core_aes_done = 1'b1;
                core_data_out = {cap[128], core_ref(ck, cm, cap[127:0])};
                check("core_data_stable", core_data, cap);
                @(posedge clk); #1;
                core_aes_done = 1'b0;
                check("done_to_out_valid", out_valid, 1'b1);
            end
        end
    end

    // Downstream ready driver: always, random, or 5-cycle stall per word
    initial begin : ready_drv
        int sc;
        sc = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 0) out_ready = 1'b1;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (!out_valid) begin out_ready = 1'b0; sc = 0; end
            else if (sc < 5) begin out_ready = 1'b0; sc++; end
            else begin out_ready = 1'b1; sc = 0; end
        end
    end

    // Scoreboard: output order, hold-while-stalled, timeout pulse count
    initial begin : monitor
        logic [32:0] held;
        bit          held_v;
        held_v = 0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (timeout_err) tmo_count++;
            if (n_rst && out_valid) begin
                if (held_v) check("out_hold", {out_last, out_data}, held);
                if (out_ready) begin
                    if (exp_q.size() == 0) check("out_unexpected", out_valid, 1'b0);
                    else check("out_word", {out_last, out_data}, exp_q.pop_front());
                    held_v = 0;
                end else begin
                    held_v = 1;
                    held   = {out_last, out_data};
                end
            end else begin
                if (held_v && n_rst) check("out_valid_drop", out_valid, 1'b1);
                held_v = 0;
            end
        end
    end

    // Driver tasks
    task automatic send_word(input logic [31:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("in_ready_timeout", in_ready, 1'b1);
    endtask

    task automatic load_key(input logic [127:0] k, input logic m);
        key_in   = k;
        ed_mode  = m;
        key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        cur_key  = k;
        cur_mode = m;
        check("ks_key_op", core_key_op, 1'b1);
        check("ks_start_op", core_start_op, 1'b1);
        check("ks_core_key", core_key, k);
        check("ks_ed_sel", core_ed_sel, m);
        check("ks_no_err", key_load_err, 1'b0);
        check("ks_ready_clr", key_ready, 1'b0);
        for (int t = 0; t < 100 && !key_ready; t++) begin
            @(posedge clk); #1;
        end
        check("key_ready", key_ready, 1'b1);
        check("ks_fill", state_dbg, S_FILL);
    endtask

    task automatic send_block(input logic [127:0] pay, input logic last, input bit push,
                              input bit mid_key);
        logic [127:0] res;
        if (push) begin
            res = core_ref(cur_key, cur_mode, pay);
            for (int w = 0; w < 4; w++)
                exp_q.push_back({(w == 3) ? last : 1'b0, res[127 - 32*w -: 32]});
        end
        for (int w = 0; w < 4; w++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_word(pay[127 - 32*w -: 32], (w == 3) ? last : 1'($urandom_range(0, 1)));
            if (mid_key && w == 1) begin
                key_in   = ~cur_key;
                ed_mode  = ~cur_mode;
                key_load = 1'b1;
                @(posedge clk); #1;
                key_load = 1'b0;
                check("illegal_kl_err", key_load_err, 1'b1);
                check("illegal_kl_key", core_key, cur_key);
            end
        end
        check("issue_start_op", core_start_op, 1'b1);
        check("issue_key_op", core_key_op, 1'b0);
        check("issue_core_data", core_data, {last, pay});
        @(posedge clk); #1;
        check("blk_wait_state", state_dbg, S_BLK_WAIT);
        check("blk_r_ready", core_r_ready, 1'b1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("drain_done", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, state_dbg, S_IDLE);
        check({tag, "_ctl"}, {key_ready, timeout_err, key_load_err, in_ready, out_valid,
                              out_last, core_key_op, core_start_op, core_r_ready}, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_core_data"}, core_data, 0);
        check({tag, "_core_key"}, {core_ed_sel, core_key}, 0);
    endtask

    initial begin : main
        int k;
        n_rst = 1'b0; key_in = '0; ed_mode = 1'b0; key_load = 1'b0;
        in_data = '0; in_last = 1'b0; in_valid = 1'b0;
        cur_key = '0; cur_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;

        // Known-answer encrypt, 10-cycle core
        load_key(FIPS_KEY, 1'b1);
        send_block(FIPS_PT, 1'b1, 1, 0);
        wait_drain();

        // Backpressure: 5-cycle stall on every word
        rdy_mode = 2;
        send_block(FIPS_PT, 1'b1, 1, 0);
        send_block(rand128(), 1'b0, 1, 0);
        wait_drain();
        rdy_mode = 0;

        // Ignored key_load after two words
        send_block(rand128(), 1'b1, 1, 1);
        wait_drain();

        // Done on the final allowed cycle beats the timeout
        blk_lat = TMO;
        send_block(rand128(), 1'b0, 1, 0);
        wait_drain();
        check("done_wins_no_tmo", tmo_count, 0);

        // Hung core: timeout 16 cycles after BLK_WAIT entry
        hang = 1;
        send_block(rand128(), 1'b0, 0, 0);
        k = 0;
        for (int t = 1; t <= 30; t++) begin
            @(posedge clk); #1;
            if (timeout_err) begin k = t; break; end
        end
        check("timeout_cycle", k, TMO);
        check("tmo_state", state_dbg, S_IDLE);
        check("tmo_key_ready", key_ready, 1'b0);
        check("tmo_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("tmo_pulse_width", timeout_err, 1'b0);
        check("tmo_count", tmo_count, 1);
        hang = 0;

        // Randomised traffic
        rdy_mode = 1;
        for (int b = 0; b < 12; b++) begin
            if (b % 4 == 0) begin
                wait_drain();
                key_lat = $urandom_range(1, TMO);
                load_key(rand128(), 1'($urandom_range(0, 1)));
            end
            blk_lat = $urandom_range(1, TMO);
            send_block(rand128(), 1'($urandom_range(0, 1)), 1, 0);
        end
        wait_drain();

        // Reset during BLK_WAIT, then a fresh run
        rdy_mode = 0;
        blk_lat  = 10;
        key_lat  = 10;
        hang     = 1;
        send_block(rand128(), 1'b1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk); #1;
        hang = 0;
        load_key(FIPS_KEY, 1'b1);
        send_block(FIPS_PT, 1'b1, 1, 0);
        wait_drain();

        // Decrypt round trip
        load_key(FIPS_KEY, 1'b0);
        send_block(FIPS_CT, 1'b1, 1, 0);
        wait_drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
